reg_file_2r1w: RTL

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_clear_fsm.sv | 59 +++++
 rtl/reg_file_2r1w.sv | 82 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizes for the two-read/one-write register file.
package rf_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear-sweep controller: on a clear request, steps through every register
// index, one per cycle, and tells the array to zero that entry.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_SWEEP;
                    cnt_d   = '0;
                end
            end
            RF_SWEEP: begin
                // Counter wraps back to zero as the last index is cleared.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = (state_q == RF_SWEEP);
        clr_we   = (state_q == RF_SWEEP);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational read ports, one write port and a
// sweep-clear engine. Define REGFILE_BYPASS_EN to forward write data to reads.
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic                         clr_we;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         wr_en;
    logic [DEPTH-1:0][WIDTH-1:0]  regs_q;
    logic [DEPTH-1:0][WIDTH-1:0]  regs_d;

    rf_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Host writes are dropped outright while a sweep owns the array.
    assign wr_en = we & ~clr_busy;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign regs_d[gi] = '0;
            end else begin : g_data
                assign regs_d[gi] = (clr_we && (clr_addr == ADDR_W'(gi))) ? '0 :
                                    (wr_en  && (waddr    == ADDR_W'(gi))) ? wdata :
                                    regs_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a, fwd_b;

    always_comb begin
        fwd_a = wr_en && (waddr == raddr_a) && !((ZERO_REG != 0) && (raddr_a == '0));
        fwd_b = wr_en && (waddr == raddr_b) && !((ZERO_REG != 0) && (raddr_b == '0));
        rdata_a = fwd_a ? wdata : regs_q[raddr_a];
        rdata_b = fwd_b ? wdata : regs_q[raddr_b];
    end
`else
    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
    end
`endif

endmodule
